// File: rtl/sync_ram_sdp.sv
// sync_ram_sdp: simple-dual-port synchronous RAM with byte-enable writes,
// 1- or 2-cycle read latency with a valid strobe, a selectable same-address
// collision rule and a hardware clear sweep after reset.
// Optional per-lane even parity with an error strobe: define SYNC_RAM_PARITY_EN.
module sync_ram_sdp #(
  parameter int ADDR_WIDTH     = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int RD_LATENCY     = 1,
  parameter int RD_MODE        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  output logic                    ready,
  output logic                    par_err
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH / 8;

  typedef enum logic [1:0] {S_CLEAR, S_READY_PEND, S_READY} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
  logic                    clr_we;
  logic                    wr_go, rd_go, bypass;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic                    rd_err;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  // Read pipeline: stage 0 samples the array, later stages add latency.
  logic [RD_LATENCY-1:0]   vld_pipe_q;
  logic [RD_LATENCY-1:0]   err_pipe_q;
  logic [DATA_WIDTH-1:0]   dat_pipe_q [RD_LATENCY];

  assign ready  = (state_q == S_READY);
  assign wr_go  = ready && wr_en;
  assign rd_go  = ready && rd_en;
  // Write-through mode forwards the write lanes into a same-address read.
  assign bypass = (RD_MODE == 1) && wr_go && (wr_addr == rd_addr);

  // State register and clear counter; reset restarts the sweep at address 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY_PEND;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Next state: sweep one location per cycle, then open for accesses.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_we    = 1'b0;
    case (state_q)
      S_CLEAR: begin
        clr_we    = 1'b1;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (&clr_cnt_q) state_d = S_READY;
      end
      S_READY_PEND: state_d = S_READY;
      default: ;
    endcase
  end

  // Array write: clear sweep has priority, otherwise per-lane byte enables.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_cnt_q] <= '0;
    end else if (wr_go) begin
      for (int b = 0; b < NB; b++)
        if (wr_be[b]) mem_q[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
    end
  end

  // Read word: old contents, or merged word when forwarding a collision.
  always_comb begin
    rd_word = mem_q[rd_addr];
    if (bypass)
      for (int b = 0; b < NB; b++)
        if (wr_be[b]) rd_word[8*b +: 8] = wr_data[8*b +: 8];
  end

`ifdef SYNC_RAM_PARITY_EN
  logic [NB-1:0] par_q [DEPTH];
  logic [NB-1:0] rd_par;

  // Parity store follows the data array lane for lane; clear writes 0.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      par_q[clr_cnt_q] <= '0;
    end else if (wr_go) begin
      for (int b = 0; b < NB; b++)
        if (wr_be[b]) par_q[wr_addr][b] <= ^wr_data[8*b +: 8];
    end
  end

  // Recompute lane parity on the read word and compare with stored bits.
  always_comb begin
    rd_par = par_q[rd_addr];
    rd_err = 1'b0;
    if (bypass)
      for (int b = 0; b < NB; b++)
        if (wr_be[b]) rd_par[b] = ^wr_data[8*b +: 8];
    for (int b = 0; b < NB; b++)
      if (rd_par[b] != ^rd_word[8*b +: 8]) rd_err = 1'b1;
  end
`else
  assign rd_err = 1'b0;
`endif

  // Read pipeline; data only moves with its valid so rd_data holds between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      err_pipe_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) dat_pipe_q[i] <= '0;
    end else begin
      vld_pipe_q[0] <= rd_go;
      if (rd_go) begin
        dat_pipe_q[0] <= rd_word;
        err_pipe_q[0] <= rd_err;
      end
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_pipe_q[i] <= vld_pipe_q[i-1];
        if (vld_pipe_q[i-1]) begin
          dat_pipe_q[i] <= dat_pipe_q[i-1];
          err_pipe_q[i] <= err_pipe_q[i-1];
        end
      end
    end
  end

  assign rd_data  = dat_pipe_q[RD_LATENCY-1];
  assign rd_valid = vld_pipe_q[RD_LATENCY-1];
  assign par_err  = vld_pipe_q[RD_LATENCY-1] & err_pipe_q[RD_LATENCY-1];

endmodule

// File: tb/tb_sync_ram_sdp.sv
// Directed bench for sync_ram_sdp: three instances share one stimulus stream
// (A: defaults, B: 2-cycle read latency + write-through, C: no clear sweep).
module tb_sync_ram_sdp;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en, rd_en;
  logic [3:0]  wr_addr, rd_addr, wr_be;
  logic [31:0] wr_data;

  logic [31:0] a_rd_data, b_rd_data, c_rd_data;
  logic        a_rd_valid, b_rd_valid, c_rd_valid;
  logic        a_ready, b_ready, c_ready;
  logic        a_par_err, b_par_err, c_par_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sync_ram_sdp dut_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(a_rd_data),
    .rd_valid(a_rd_valid), .ready(a_ready), .par_err(a_par_err));

  sync_ram_sdp #(.RD_LATENCY(2), .RD_MODE(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(b_rd_data),
    .rd_valid(b_rd_valid), .ready(b_ready), .par_err(b_par_err));

  sync_ram_sdp #(.CLEAR_ON_RESET(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(c_rd_data),
    .rd_valid(c_rd_valid), .ready(c_ready), .par_err(c_par_err));

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_be = '0; wr_data = '0;
    repeat (2) step();

    // Reset state
    chk1 ("rst_ready",   a_ready,    1'b0);
    chk1 ("rst_valid",   a_rd_valid, 1'b0);
    chk32("rst_data",    a_rd_data,  32'h0);
    chk1 ("rst_par",     a_par_err,  1'b0);
    chk1 ("rst_c_ready", c_ready,    1'b0);

    // Clear sweep: ready rises on the 16th edge; no-clear build on the 1st
    rst_n = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      chk1("clr_ready", a_ready, (i == 16));
      if (i == 1) chk1("pend_ready", c_ready, 1'b1);
    end

    // Every location reads back zero, one read per cycle
    rd_en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      rd_addr = 4'(k);
      step();
      chk1 ("clr_rd_valid", a_rd_valid, 1'b1);
      chk32("clr_rd_data",  a_rd_data,  32'h0);
    end
    rd_en = 1'b0;

    // Byte enables
    wr_en = 1'b1; wr_addr = 4'd3; wr_be = 4'b1111; wr_data = 32'hAABBCCDD;
    step();
    wr_be = 4'b0101; wr_data = 32'h11223344;
    step();
    wr_en = 1'b0; rd_en = 1'b1; rd_addr = 4'd3;
    step();
    chk1 ("be_valid", a_rd_valid, 1'b1);
    chk32("be_data",  a_rd_data,  32'hAA22CC44);
    rd_en = 1'b0;
    step();
    chk1 ("idle_valid", a_rd_valid, 1'b0);
    chk32("idle_hold",  a_rd_data,  32'hAA22CC44);
    chk1 ("be_b_valid", b_rd_valid, 1'b1);
    chk32("be_b_data",  b_rd_data,  32'hAA22CC44);
    step();
    chk1 ("be_b_idle",  b_rd_valid, 1'b0);

    // Latency / throughput on the 2-cycle instance
    wr_en = 1'b1; wr_be = 4'b1111;
    wr_addr = 4'd1; wr_data = 32'h01010101;
    step();
    wr_addr = 4'd2; wr_data = 32'h02020202;
    step();
    wr_en = 1'b0; rd_en = 1'b1; rd_addr = 4'd1;
    step();
    chk1 ("lat_e1_b_valid", b_rd_valid, 1'b0);
    chk32("lat_e1_a_data",  a_rd_data,  32'h01010101);
    rd_addr = 4'd2;
    step();
    chk1 ("lat_e2_valid", b_rd_valid, 1'b1);
    chk32("lat_e2_data",  b_rd_data,  32'h01010101);
    rd_addr = 4'd3;
    step();
    chk1 ("lat_e3_valid", b_rd_valid, 1'b1);
    chk32("lat_e3_data",  b_rd_data,  32'h02020202);
    rd_en = 1'b0;
    step();
    chk1 ("lat_e4_valid", b_rd_valid, 1'b1);
    chk32("lat_e4_data",  b_rd_data,  32'hAA22CC44);
    step();
    chk1 ("lat_e5_valid", b_rd_valid, 1'b0);
    chk32("lat_e5_hold",  b_rd_data,  32'hAA22CC44);

    // Collision: read-first (A) versus write-through (B)
    wr_en = 1'b1; wr_addr = 4'd5; wr_be = 4'b1111; wr_data = 32'h00000001;
    step();
    wr_data = 32'hFFFFFFFF; rd_en = 1'b1; rd_addr = 4'd5;
    step();
    chk32("col_rf_data", a_rd_data, 32'h00000001);
    wr_en = 1'b0; rd_en = 1'b0;
    step();
    chk32("col_wt_data", b_rd_data, 32'hFFFFFFFF);
    // Partial-lane collision
    wr_en = 1'b1; wr_be = 4'b0001; wr_data = 32'h00000000; rd_en = 1'b1;
    step();
    chk32("colp_rf_data", a_rd_data, 32'hFFFFFFFF);
    wr_en = 1'b0; rd_en = 1'b0;
    step();
    chk32("colp_wt_data", b_rd_data, 32'hFFFFFF00);
    // wr_be = 0 is a no-op
    wr_en = 1'b1; wr_be = 4'b0000; wr_data = 32'h0;
    step();
    wr_en = 1'b0; rd_en = 1'b1;
    step();
    chk32("be0_noop", a_rd_data, 32'hFFFFFF00);
    // Different addresses do not interact
    wr_en = 1'b1; wr_addr = 4'd6; wr_be = 4'b1111; wr_data = 32'h12345678;
    step();
    chk32("diff_rf", a_rd_data, 32'hFFFFFF00);
    wr_en = 1'b0; rd_en = 1'b0;
    step();
    chk32("diff_wt", b_rd_data, 32'hFFFFFF00);
    rd_en = 1'b1; rd_addr = 4'd6;
    step();
    chk32("diff_rd6", a_rd_data, 32'h12345678);
    rd_en = 1'b0;

    // Reset mid-clear
    rst_n = 1'b0;
    #1;
    chk1 ("rst2_ready", a_ready,    1'b0);
    chk1 ("rst2_valid", a_rd_valid, 1'b0);
    chk32("rst2_data",  a_rd_data,  32'h0);
    chk32("rst2_bdata", b_rd_data,  32'h0);
    step();
    rst_n = 1'b1;
    repeat (7) step();
    chk1("mid_ready", a_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    chk1("mid_rst_ready", a_ready, 1'b0);
    step();
    rst_n = 1'b1;
    wr_en = 1'b1; wr_addr = 4'd4; wr_be = 4'b1111; wr_data = 32'hDEADBEEF;
    rd_en = 1'b1; rd_addr = 4'd0;
    for (int i = 1; i <= 16; i++) begin
      step();
      chk1("reclr_ready", a_ready, (i == 16));
      chk1("reclr_valid", a_rd_valid, 1'b0);
    end
    wr_en = 1'b0; rd_addr = 4'd3;
    step();
    chk1 ("reclr_rd3_valid", a_rd_valid, 1'b1);
    chk32("reclr_rd3_data",  a_rd_data,  32'h0);
    rd_addr = 4'd4;
    step();
    chk32("reclr_rd4_data",  a_rd_data,  32'h0);
    rd_en = 1'b0;
    step();

`ifdef SYNC_RAM_PARITY_EN
    // Parity: corrupt stored lane 0 behind the write port
    wr_en = 1'b1; wr_addr = 4'd2; wr_be = 4'b1111; wr_data = 32'h000000FF;
    step();
    wr_en = 1'b0;
    dut_a.mem_q[2] = 32'h000000FE;
    rd_en = 1'b1; rd_addr = 4'd2;
    step();
    chk1("par_valid", a_rd_valid, 1'b1);
    chk1("par_err",   a_par_err,  1'b1);
    rd_addr = 4'd3;
    step();
    chk1("par_clean", a_par_err,  1'b0);
    rd_en = 1'b0;
    step();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sync_ram_sdp.md
Name: sync_ram_sdp

Overview:
- Parametrised simple-dual-port synchronous RAM: one write port and one independent read port, both in the `clk` domain.
- Adds several features over the single-port RAM:
  - byte-enable writes
  - configurable read latency with a valid strobe
  - defined read-during-write collision behaviour
  - hardware memory clear after reset
- Used as the general scratch/buffer store for datapath blocks.

Parameters:
- ADDR_WIDTH, 4, address bits; DEPTH = 2**ADDR_WIDTH locations.
- DATA_WIDTH, 32, word width; must be a multiple of 8; NB = DATA_WIDTH/8 byte lanes.
- RD_LATENCY, 1, cycles from accepted rd_en to rd_valid; legal values 1 or 2.
- RD_MODE, 0, same-address collision rule: 0 = read-first (old data), 1 = write-through (new data).
- CLEAR_ON_RESET, 1, 1 = zero every location after reset; 0 = no clear (contents undefined).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_be  in  NB  byte enables; bit i selects wr_data[8i+7:8i].
- wr_data  in  DATA_WIDTH  write data.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_WIDTH  read address.
- rd_data  out  DATA_WIDTH  read data; holds its value between reads.
- rd_valid  out  1  one-cycle strobe marking new rd_data.
- ready  out  1  high when the RAM accepts accesses.
- par_err  out  1  parity error strobe (see Optional Feature).

Behaviour:
- Reset (rst_n low, asynchronous):
  - rd_data = 0, rd_valid = 0, ready = 0, par_err = 0.
  - Read pipeline flushed; FSM forced to CLEAR (CLEAR_ON_RESET = 1) or READY_PEND (CLEAR_ON_RESET = 0).
- FSM states: CLEAR, READY_PEND, READY.
  - CLEAR: clear counter starts at 0; one location written with all-zero data per cycle; after writing DEPTH-1, go to READY. ready rises on the cycle after the last clear write (exactly DEPTH clock edges after rst_n release).
  - READY_PEND: go to READY on the first edge; ready = 1 from then on.
  - Reset asserted mid-CLEAR aborts the sweep; it restarts from address 0 on release.
- wr_en and rd_en are ignored while ready = 0: no writes, no rd_valid.
- Write (ready = 1, wr_en = 1):
  - On the edge, byte lane i of mem[wr_addr] takes wr_data lane i where wr_be[i] = 1; other lanes unchanged.
  - wr_be = 0 is a no-op.
- Read (ready = 1, rd_en = 1):
  - mem[rd_addr] is sampled on the edge.
  - RD_LATENCY = 1: rd_data updates and rd_valid = 1 on that edge.
  - RD_LATENCY = 2: one additional output register stage, so data and valid appear one edge later.
  - Full throughput: a read may be accepted every cycle, so rd_valid may stay high on consecutive cycles.
- Collision (wr_en and rd_en in the same cycle, wr_addr == rd_addr):
  - RD_MODE 0: the read returns pre-write contents.
  - RD_MODE 1: the read returns the merged word (enabled lanes from wr_data, others old).
  - Different addresses never interact.
- rd_valid is low on any cycle with no read completing; rd_data holds its last value.

Optional Feature:
- Macro SYNC_RAM_PARITY_EN.
- Defined:
  - One even-parity bit is stored per byte lane and written with that lane's data; clear writes parity 0.
  - On each completing read, parity is recomputed per lane. par_err = 1 in the same cycle as rd_valid if any lane mismatches; 0 otherwise.
  - A hidden-state error can only arise via a bench backdoor force on the memory array.
- Undefined: no parity storage; par_err is tied to 0.

Test Plan:
- Clear sweep: release rst_n (defaults) -> ready stays 0 for 16 edges, rises on the 16th; reads of addrs 0..15 return 0x00000000.
- Byte enables: write 0xAABBCCDD to addr 3 with wr_be = 4'b1111, then 0x11223344 with wr_be = 4'b0101 -> read of addr 3 returns 0xAA22CC44.
- Latency/throughput: RD_LATENCY = 2, reads of addrs 1,2,3 on consecutive cycles -> rd_valid high for 3 cycles starting 2 edges after the first rd_en, data in order.
- Collision: addr 5 holds 0x00000001; write 0xFFFFFFFF and read addr 5 in the same cycle -> RD_MODE 0 returns 0x00000001; RD_MODE 1 returns 0xFFFFFFFF.
- Reset mid-clear: assert rst_n low at clear address 7, release -> ready takes a full 16 edges again; rd_en during clear gives no rd_valid.
- Parity (macro defined): write 0x000000FF to addr 2, force stored lane-0 data to 0xFE, read addr 2 -> par_err = 1 with rd_valid; read of a clean address gives par_err = 0.
